aes_decrypt_round_sequencer: RTL and testbench
==============================================

# aes_decrypt_round_sequencer

Iterative control block for AES-128 decryption. It accepts one 128-bit ciphertext block through a valid/ready handshake. It then runs the block once through the external first-round unit (AddRoundKey k10, InvShiftRows, InvSubBytes) and nine times through the shared decryption round unit (AddRoundKey, InvMixColumns, InvShiftRows, InvSubBytes) with keys k9..k1. Finally it applies AddRoundKey k0 internally and presents the plaintext on a valid/ready output. It sits between the block-level I/O, the round-key store and the two round datapath instances.

## Interface
- ROUND_LAT, 1, clock edges from a stable round-unit input to a valid round-unit output; legal range 1..14.

- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- IN_VALID  in  1  ciphertext valid
- IN_READY  out  1  sequencer can accept a block
- IN_DATA  in  128  ciphertext
- KEY_IDX  out  4  round-key index to the key store
- KEY_IN  in  128  round key for KEY_IDX; combinational, same cycle
- FR_DATA  out  128  first-round unit data input
- FR_KEY  out  128  first-round unit key input
- FR_RESULT  in  128  first-round unit output
- RR_DATA  out  128  round unit data input
- RR_KEY  out  128  round unit key input
- RR_RESULT  in  128  round unit output
- OUT_VALID  out  1  plaintext valid
- OUT_READY  in  1  consumer accepts plaintext
- OUT_DATA  out  128  plaintext
- BUSY  out  1  high in every state except IDLE

## Operation
- Registers:
  - STATE (IDLE, FIRST, ROUND, FINAL, OUTPUT)
  - state_reg[127:0]
  - KEY_IDX[3:0] (registered)
  - wait_cnt[3:0]
  - OUT_DATA[127:0]
- Combinational outputs:
  - FR_DATA = RR_DATA = state_reg.
  - FR_KEY = RR_KEY = KEY_IN.
  - IN_READY = (STATE==IDLE).
  - OUT_VALID = (STATE==OUTPUT).
- IDLE:
  - On IN_VALID & IN_READY: state_reg <= IN_DATA, KEY_IDX <= 10, wait_cnt <= 0, go to FIRST.
- FIRST:
  - wait_cnt increments each cycle.
  - When wait_cnt==ROUND_LAT: state_reg <= FR_RESULT, KEY_IDX <= 9, wait_cnt <= 0, go to ROUND.
- ROUND:
  - wait_cnt increments each cycle.
  - When wait_cnt==ROUND_LAT: state_reg <= RR_RESULT and wait_cnt <= 0.
  - If KEY_IDX==1: KEY_IDX <= 0 and go to FINAL. Otherwise KEY_IDX <= KEY_IDX-1 and stay in ROUND.
- FINAL (one cycle):
  - OUT_DATA <= state_reg ^ KEY_IN (KEY_IDX==0), go to OUTPUT.
- OUTPUT:
  - Hold OUT_DATA until OUT_READY. Then go to IDLE; KEY_IDX <= 0.
- IN_VALID outside IDLE is ignored; no buffering, one block in flight.
- RR_RESULT and FR_RESULT are sampled only on the capture cycle (wait_cnt==ROUND_LAT) and ignored otherwise.
- Round unit inputs (state_reg, KEY_IDX, hence KEY_IN) stay constant for every cycle of a phase.
- Arithmetic: all data ops are bitwise XOR, no carries. wait_cnt and KEY_IDX never wrap; KEY_IDX never underflows below 0.

## Timing
- Reset values (rst_n low at a rising edge):
  - STATE=IDLE; state_reg, OUT_DATA, KEY_IDX, wait_cnt = 0.
  - OUT_VALID=0, BUSY=0, IN_READY=1 from the first cycle after reset.
- Reset mid-operation: the block is dropped, no OUT_VALID pulse; the next accepted block decrypts correctly.
- Phase length: FIRST and each ROUND last ROUND_LAT+1 cycles.
- Latency:
  - OUT_VALID first high 10·(ROUND_LAT+1)+2 cycles after the accept cycle.
  - ROUND_LAT=1: accept cycle 0, OUT_VALID at cycle 22.
- OUT_VALID/OUT_DATA stay stable under backpressure until the handshake cycle. OUT_VALID falls the cycle after it.
- IN_READY rises the cycle after the output handshake.
- Minimum block-to-block period: 10·(ROUND_LAT+1)+3 cycles.
- KEY_IDX sequence per block: 10, 9, 8, …, 1, 0. Each value is held for its full phase.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key store loaded with the expansion of 000102030405060708090a0b0c0d0e0f; IN_DATA=69c4e0d86a7b0430d8cdb78070b4c55a; OUT_READY=1.
  - Required response: OUT_DATA=00112233445566778899aabbccddeeff with OUT_VALID at cycle 22.
- Backpressure:
  - Stimulus: same vector with OUT_READY low for 7 cycles after OUT_VALID rises.
  - Required response: OUT_VALID and OUT_DATA held stable for 8 cycles; IN_READY low throughout; IN_READY high the cycle after the handshake.
- Busy input ignored:
  - Stimulus: IN_VALID held high with changing IN_DATA while BUSY.
  - Required response: only the first block is consumed; output is that block's plaintext.
- Back-to-back blocks:
  - Stimulus: two C.1 blocks.
  - Required response: two correct outputs, 23 cycles apart.
- Reset mid-operation:
  - Stimulus: rst_n low at cycle 10 of a block.
  - Required response: next cycle OUT_VALID=0, BUSY=0, KEY_IDX=0; a fresh block then decrypts correctly.
- Latency parameter:
  - Stimulus: ROUND_LAT=3 with round models of 3-cycle latency.
  - Required response: correct plaintext with OUT_VALID at cycle 42; KEY_IDX sequence checked cycle by cycle.

Source files
------------

// File: rtl/aes_decrypt_round_sequencer.sv
// Iterative AES-128 decryption controller: steps one block through the external
// first-round unit once and the shared round unit nine times, then adds k0.
module aes_decrypt_round_sequencer #(
  parameter int ROUND_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         IN_VALID,
  output logic         IN_READY,
  input  logic [127:0] IN_DATA,
  output logic [3:0]   KEY_IDX,
  input  logic [127:0] KEY_IN,
  output logic [127:0] FR_DATA,
  output logic [127:0] FR_KEY,
  input  logic [127:0] FR_RESULT,
  output logic [127:0] RR_DATA,
  output logic [127:0] RR_KEY,
  input  logic [127:0] RR_RESULT,
  output logic         OUT_VALID,
  input  logic         OUT_READY,
  output logic [127:0] OUT_DATA,
  output logic         BUSY
);

  typedef enum logic [2:0] {
    IDLE,
    FIRST,
    ROUND,
    FINAL,
    OUTPUT
  } fsm_state_e;

  localparam logic [3:0] LAT = 4'(ROUND_LAT);

  fsm_state_e   fsm_state;
  fsm_state_e   fsm_next;
  logic [127:0] state_reg;
  logic [3:0]   wait_cnt;
  logic         phase_done;

  // A phase ends once the round unit has had ROUND_LAT edges with stable inputs.
  assign phase_done = (wait_cnt == LAT);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm_state <= IDLE;
    end else begin
      fsm_state <= fsm_next;
    end
  end

  always_comb begin
    fsm_next = fsm_state;
    case (fsm_state)
      IDLE:    if (IN_VALID) fsm_next = FIRST;
      FIRST:   if (phase_done) fsm_next = ROUND;
      ROUND:   if (phase_done && (KEY_IDX == 4'd1)) fsm_next = FINAL;
      FINAL:   fsm_next = OUTPUT;
      OUTPUT:  if (OUT_READY) fsm_next = IDLE;
      default: fsm_next = IDLE;
    endcase
  end

  always_comb begin
    IN_READY  = (fsm_state == IDLE);
    OUT_VALID = (fsm_state == OUTPUT);
    BUSY      = (fsm_state != IDLE);
  end

  // Both round units see the same operands; only the active phase samples a result.
  assign FR_DATA = state_reg;
  assign RR_DATA = state_reg;
  assign FR_KEY  = KEY_IN;
  assign RR_KEY  = KEY_IN;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= '0;
      KEY_IDX   <= '0;
      wait_cnt  <= '0;
      OUT_DATA  <= '0;
    end else begin
      case (fsm_state)
        IDLE: begin
          if (IN_VALID) begin
            state_reg <= IN_DATA;
            KEY_IDX   <= 4'd10;
            wait_cnt  <= '0;
          end
        end
        FIRST: begin
          if (phase_done) begin
            state_reg <= FR_RESULT;
            KEY_IDX   <= 4'd9;
            wait_cnt  <= '0;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        ROUND: begin
          if (phase_done) begin
            state_reg <= RR_RESULT;
            wait_cnt  <= '0;
            KEY_IDX   <= (KEY_IDX <= 4'd1) ? 4'd0 : KEY_IDX - 4'd1;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        FINAL: begin
          OUT_DATA <= state_reg ^ KEY_IN;
        end
        OUTPUT: begin
          if (OUT_READY) KEY_IDX <= '0;
        end
        default: begin
          KEY_IDX <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_decrypt_round_sequencer.sv
// Bench for aes_decrypt_round_sequencer: two instances (ROUND_LAT 1 and 3) driven by
// behavioural round units and a key store, checked against a plain FIPS-197 InvCipher.
module tb_aes_decrypt_round_sequencer;

  localparam int LAT_A = 1;
  localparam int LAT_B = 3;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [127:0] in_data   [2];
  logic [3:0]   key_idx   [2];
  logic [127:0] key_in    [2];
  logic [127:0] fr_data   [2];
  logic [127:0] fr_key    [2];
  logic [127:0] fr_result [2];
  logic [127:0] rr_data   [2];
  logic [127:0] rr_key    [2];
  logic [127:0] rr_result [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] out_data  [2];
  logic         busy      [2];

  logic [7:0]   sbox     [0:255];
  logic [7:0]   inv_sbox [0:255];
  logic [127:0] rk       [0:15];
  logic [127:0] fr_pipe  [2][3];
  logic [127:0] rr_pipe  [2][3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  aes_decrypt_round_sequencer #(.ROUND_LAT(LAT_A)) u_dut_lat1 (
    .clk(clk), .rst_n(rst_n),
    .IN_VALID(in_valid[0]), .IN_READY(in_ready[0]), .IN_DATA(in_data[0]),
    .KEY_IDX(key_idx[0]), .KEY_IN(key_in[0]),
    .FR_DATA(fr_data[0]), .FR_KEY(fr_key[0]), .FR_RESULT(fr_result[0]),
    .RR_DATA(rr_data[0]), .RR_KEY(rr_key[0]), .RR_RESULT(rr_result[0]),
    .OUT_VALID(out_valid[0]), .OUT_READY(out_ready[0]), .OUT_DATA(out_data[0]),
    .BUSY(busy[0])
  );

  aes_decrypt_round_sequencer #(.ROUND_LAT(LAT_B)) u_dut_lat3 (
    .clk(clk), .rst_n(rst_n),
    .IN_VALID(in_valid[1]), .IN_READY(in_ready[1]), .IN_DATA(in_data[1]),
    .KEY_IDX(key_idx[1]), .KEY_IN(key_in[1]),
    .FR_DATA(fr_data[1]), .FR_KEY(fr_key[1]), .FR_RESULT(fr_result[1]),
    .RR_DATA(rr_data[1]), .RR_KEY(rr_key[1]), .RR_RESULT(rr_result[1]),
    .OUT_VALID(out_valid[1]), .OUT_READY(out_ready[1]), .OUT_DATA(out_data[1]),
    .BUSY(busy[1])
  );

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
    logic [7:0] a, b, p;
    a = a_in; b = b_in; p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = xtime(a);
      b = b >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: GF(2^8) inverse (x^254) then the affine map.
  function automatic logic [7:0] sbox_calc(input logic [7:0] x);
    logic [7:0] r, s, r1, r2, r3, r4;
    r = 8'h01; s = x;
    for (int i = 1; i < 8; i++) begin
      s = gmul(s, s);
      r = gmul(r, s);
    end
    r1 = {r[6:0], r[7]};
    r2 = {r1[6:0], r1[7]};
    r3 = {r2[6:0], r2[7]};
    r4 = {r3[6:0], r3[7]};
    return r ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
  endfunction

  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*((c+r)%4)) -: 8] = s[127-8*(r+4*c) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = inv_sbox[s[127-8*k -: 8]];
    return o;
  endfunction

  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0] a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-8*(4*c)   -: 8];
      a1 = s[127-8*(4*c+1) -: 8];
      a2 = s[127-8*(4*c+2) -: 8];
      a3 = s[127-8*(4*c+3) -: 8];
      o[127-8*(4*c)   -: 8] = gmul(a0, 8'd14) ^ gmul(a1, 8'd11) ^ gmul(a2, 8'd13) ^ gmul(a3, 8'd9);
      o[127-8*(4*c+1) -: 8] = gmul(a0, 8'd9)  ^ gmul(a1, 8'd14) ^ gmul(a2, 8'd11) ^ gmul(a3, 8'd13);
      o[127-8*(4*c+2) -: 8] = gmul(a0, 8'd13) ^ gmul(a1, 8'd9)  ^ gmul(a2, 8'd14) ^ gmul(a3, 8'd11);
      o[127-8*(4*c+3) -: 8] = gmul(a0, 8'd11) ^ gmul(a1, 8'd13) ^ gmul(a2, 8'd9)  ^ gmul(a3, 8'd14);
    end
    return o;
  endfunction

  function automatic logic [127:0] first_round_fn(input logic [127:0] d, input logic [127:0] k);
    return inv_sub_bytes(inv_shift_rows(d ^ k));
  endfunction

  function automatic logic [127:0] round_fn(input logic [127:0] d, input logic [127:0] k);
    return inv_sub_bytes(inv_shift_rows(inv_mix_columns(d ^ k)));
  endfunction

  // Reference: textbook InvCipher over the whole block.
  function automatic logic [127:0] ref_decrypt(input logic [127:0] ct);
    logic [127:0] s;
    s = ct ^ rk[10];
    for (int r = 9; r >= 1; r--) begin
      s = inv_sub_bytes(inv_shift_rows(s));
      s = inv_mix_columns(s ^ rk[r]);
    end
    return inv_sub_bytes(inv_shift_rows(s)) ^ rk[0];
  endfunction

  task automatic expand_key(input logic [127:0] key);
    logic [31:0] w [0:43];
    logic [31:0] t;
    logic [7:0]  rc;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    for (int r = 11; r < 16; r++) rk[r] = '0;
  endtask

  assign key_in[0]    = rk[key_idx[0]];
  assign key_in[1]    = rk[key_idx[1]];
  assign fr_result[0] = fr_pipe[0][0];
  assign rr_result[0] = rr_pipe[0][0];
  assign fr_result[1] = fr_pipe[1][2];
  assign rr_result[1] = rr_pipe[1][2];

  // Round units modelled as delay lines; only the last stage reaches the DUT.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      for (int s = 2; s > 0; s--) begin
        fr_pipe[i][s] <= fr_pipe[i][s-1];
        rr_pipe[i][s] <= rr_pipe[i][s-1];
      end
      fr_pipe[i][0] <= first_round_fn(fr_data[i], fr_key[i]);
      rr_pipe[i][0] <= round_fn(rr_data[i], rr_key[i]);
    end
  end

  task automatic run_block(input int u, input logic [127:0] ct, output int lat,
                           output logic [127:0] pt, output bit timed_out);
    int n;
    int guard;
    guard = 0;
    while (!in_ready[u] && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    in_valid[u] = 1'b1;
    in_data[u]  = ct;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) in_valid[u] = 1'b0;
    end while (!out_valid[u] && n < 300);
    timed_out = !out_valid[u];
    lat = n;
    pt  = out_data[u];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checks++; if (in_ready[u] !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready u%0d got %b want 1", u, in_ready[u]); end
      checks++; if (out_valid[u] !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid u%0d got %b want 0", u, out_valid[u]); end
      checks++; if (busy[u] !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy u%0d got %b want 0", u, busy[u]); end
      checks++; if (key_idx[u] !== 4'd0) begin errors++; $display("[TB] FAIL reset_key_idx u%0d got %0d want 0", u, key_idx[u]); end
      checks++; if (out_data[u] !== 128'h0) begin errors++; $display("[TB] FAIL reset_out_data u%0d got %h want 0", u, out_data[u]); end
      checks++; if (fr_data[u] !== 128'h0) begin errors++; $display("[TB] FAIL reset_state_reg u%0d got %h want 0", u, fr_data[u]); end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_fips_vector();
    int lat;
    logic [127:0] pt;
    bit to;
    expand_key(C1_KEY);
    @(negedge clk);
    run_block(0, C1_CT, lat, pt, to);
    checks++; if (to) begin errors++; $display("[TB] FAIL fips_timeout got no OUT_VALID want OUT_VALID"); end
    checks++; if (lat != 22) begin errors++; $display("[TB] FAIL fips_latency got %0d want 22", lat); end
    checks++; if (pt !== C1_PT) begin errors++; $display("[TB] FAIL fips_data got %h want %h", pt, C1_PT); end
  endtask

  task automatic test_backpressure();
    int n;
    expand_key(C1_KEY);
    @(negedge clk);
    out_ready[0] = 1'b0;
    in_valid[0]  = 1'b1;
    in_data[0]   = C1_CT;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) in_valid[0] = 1'b0;
    end while (!out_valid[0] && n < 300);
    checks++;
    if (!out_valid[0]) begin
      errors++; $display("[TB] FAIL bp_timeout got no OUT_VALID want OUT_VALID");
    end else if (n != 22) begin
      errors++; $display("[TB] FAIL bp_latency got %0d want 22", n);
    end
    for (int k = 0; k < 8; k++) begin
      if (k > 0) @(negedge clk);
      checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL bp_hold_valid k%0d got %b want 1", k, out_valid[0]); end
      checks++; if (out_data[0] !== C1_PT) begin errors++; $display("[TB] FAIL bp_hold_data k%0d got %h want %h", k, out_data[0], C1_PT); end
      checks++; if (in_ready[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_in_ready_low k%0d got %b want 0", k, in_ready[0]); end
    end
    out_ready[0] = 1'b1;
    @(negedge clk);
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL bp_in_ready_after got %b want 1", in_ready[0]); end
    checks++; if (out_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL bp_valid_fall got %b want 0", out_valid[0]); end
  endtask

  task automatic test_busy_ignored();
    int n;
    bit busy_ok;
    expand_key(C1_KEY);
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = C1_CT;
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk);
      n++;
      in_data[0] = {$urandom, $urandom, $urandom, $urandom};
      if (!out_valid[0] && (busy[0] !== 1'b1 || in_ready[0] !== 1'b0)) busy_ok = 1'b0;
    end while (!out_valid[0] && n < 300);
    in_valid[0] = 1'b0;
    checks++; if (out_valid[0] !== 1'b1) begin errors++; $display("[TB] FAIL busy_timeout got %b want 1", out_valid[0]); end
    checks++; if (n != 22) begin errors++; $display("[TB] FAIL busy_latency got %0d want 22", n); end
    checks++; if (out_data[0] !== C1_PT) begin errors++; $display("[TB] FAIL busy_data got %h want %h", out_data[0], C1_PT); end
    checks++; if (!busy_ok) begin errors++; $display("[TB] FAIL busy_flags got busy/in_ready wrong while busy want busy=1 in_ready=0"); end
    @(negedge clk);
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL busy_in_ready_after got %b want 1", in_ready[0]); end
    @(negedge clk);
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("[TB] FAIL busy_no_reaccept got %b want 0", busy[0]); end
  endtask

  task automatic test_back_to_back();
    int n, nout, drop_at;
    int out_cyc [2];
    logic [127:0] out_val [2];
    expand_key(C1_KEY);
    out_cyc = '{0, 0};
    out_val = '{128'h0, 128'h0};
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = C1_CT;
    n = 0; nout = 0; drop_at = -1;
    do begin
      @(negedge clk);
      n++;
      if (out_valid[0]) begin
        out_cyc[nout] = n;
        out_val[nout] = out_data[0];
        nout++;
        if (nout == 1) drop_at = n + 2;
      end
      if (n == drop_at) in_valid[0] = 1'b0;
    end while (nout < 2 && n < 300);
    in_valid[0] = 1'b0;
    checks++; if (nout != 2) begin errors++; $display("[TB] FAIL b2b_count got %0d want 2", nout); end
    checks++; if (out_cyc[0] != 22) begin errors++; $display("[TB] FAIL b2b_first_cycle got %0d want 22", out_cyc[0]); end
    checks++; if (out_cyc[1] - out_cyc[0] != 23) begin errors++; $display("[TB] FAIL b2b_spacing got %0d want 23", out_cyc[1] - out_cyc[0]); end
    checks++; if (out_val[0] !== C1_PT) begin errors++; $display("[TB] FAIL b2b_data0 got %h want %h", out_val[0], C1_PT); end
    checks++; if (out_val[1] !== C1_PT) begin errors++; $display("[TB] FAIL b2b_data1 got %h want %h", out_val[1], C1_PT); end
  endtask

  task automatic test_reset_mid_op();
    int n, lat;
    bit saw_out, to;
    logic [127:0] ct, pt;
    expand_key(C1_KEY);
    @(negedge clk);
    in_valid[0] = 1'b1;
    in_data[0]  = C1_CT;
    n = 0; saw_out = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) in_valid[0] = 1'b0;
      if (out_valid[0]) saw_out = 1'b1;
    end while (n < 10);
    rst_n = 1'b0;
    @(negedge clk);
    checks++; if (saw_out || out_valid[0] !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_out_valid got %b want 0", out_valid[0] | saw_out); end
    checks++; if (busy[0] !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy got %b want 0", busy[0]); end
    checks++; if (key_idx[0] !== 4'd0) begin errors++; $display("[TB] FAIL rst_mid_key_idx got %0d want 0", key_idx[0]); end
    checks++; if (in_ready[0] !== 1'b1) begin errors++; $display("[TB] FAIL rst_mid_in_ready got %b want 1", in_ready[0]); end
    rst_n = 1'b1;
    expand_key({$urandom, $urandom, $urandom, $urandom});
    ct = {$urandom, $urandom, $urandom, $urandom};
    run_block(0, ct, lat, pt, to);
    checks++; if (to || lat != 22) begin errors++; $display("[TB] FAIL rst_mid_latency got %0d want 22", lat); end
    checks++; if (pt !== ref_decrypt(ct)) begin errors++; $display("[TB] FAIL rst_mid_data got %h want %h", pt, ref_decrypt(ct)); end
  endtask

  task automatic test_latency_param();
    int n;
    logic [3:0] exp_idx;
    expand_key(C1_KEY);
    @(negedge clk);
    in_valid[1] = 1'b1;
    in_data[1]  = C1_CT;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) in_valid[1] = 1'b0;
      exp_idx = (n <= 10 * (LAT_B + 1)) ? 4'(10 - (n - 1) / (LAT_B + 1)) : 4'd0;
      checks++;
      if (key_idx[1] !== exp_idx) begin
        errors++; $display("[TB] FAIL lat3_key_idx cycle %0d got %0d want %0d", n, key_idx[1], exp_idx);
      end
    end while (!out_valid[1] && n < 300);
    checks++; if (n != 10 * (LAT_B + 1) + 2) begin errors++; $display("[TB] FAIL lat3_latency got %0d want %0d", n, 10 * (LAT_B + 1) + 2); end
    checks++; if (out_data[1] !== C1_PT) begin errors++; $display("[TB] FAIL lat3_data got %h want %h", out_data[1], C1_PT); end
  endtask

  task automatic test_random_blocks();
    int lat, exp_lat;
    bit to;
    logic [127:0] ct, pt, exp_pt;
    for (int it = 0; it < 4; it++) begin
      @(negedge clk);
      expand_key({$urandom, $urandom, $urandom, $urandom});
      for (int u = 0; u < 2; u++) begin
        ct = {$urandom, $urandom, $urandom, $urandom};
        exp_pt  = ref_decrypt(ct);
        exp_lat = 10 * (((u == 0) ? LAT_A : LAT_B) + 1) + 2;
        run_block(u, ct, lat, pt, to);
        checks++; if (to) begin errors++; $display("[TB] FAIL rand_timeout it%0d u%0d got no OUT_VALID want OUT_VALID", it, u); end
        checks++; if (lat != exp_lat) begin errors++; $display("[TB] FAIL rand_latency it%0d u%0d got %0d want %0d", it, u, lat, exp_lat); end
        checks++; if (pt !== exp_pt) begin errors++; $display("[TB] FAIL rand_data it%0d u%0d got %h want %h", it, u, pt, exp_pt); end
      end
    end
  endtask

  initial begin
    for (int x = 0; x < 256; x++) begin
      sbox[x] = sbox_calc(8'(x));
      inv_sbox[sbox[x]] = 8'(x);
    end
    for (int r = 0; r < 16; r++) rk[r] = '0;
    rst_n = 1'b0;
    for (int u = 0; u < 2; u++) begin
      in_valid[u]  = 1'b0;
      in_data[u]   = '0;
      out_ready[u] = 1'b1;
    end
    test_reset();
    test_fips_vector();
    test_backpressure();
    test_busy_ignored();
    test_back_to_back();
    test_reset_mid_op();
    test_latency_param();
    test_random_blocks();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog got no completion want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
